// File: rtl/can_pulse_pkg.sv
// Shared encodings and default widths for the CAN controller pulse/level helpers.
package can_pulse_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned DROP_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StHold = ST_HOLD,
        StGap  = ST_GAP
    } state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; flags the last counted cycle via at_one.
module load_down_counter
    import can_pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_one
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority so a reload on the final cycle never sees the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign count  = cnt_q;
    assign at_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into registered levels with optional dead-time,
// retrigger and a saturating count of discarded pulses.
module pulse_stretcher
    import can_pulse_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  pulse_len,
    input  logic [CNT_W-1:0]  gap_len,
    input  logic              retrigger_en,
    output logic              level_out,
    output logic              busy,
    output logic              dropped,
    output logic [DROP_W-1:0] drop_count
);

    state_e state_q, state_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt_count;
    logic              cnt_at_one;
    logic              cnt_last;
    logic [CNT_W-1:0]  len_eff;

    logic              drop;
    logic              level_q;
    logic              busy_q;
    logic              dropped_q;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    load_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (cnt_count),
        .at_one   (cnt_at_one)
    );

    assign len_eff  = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    // A zero count in HOLD/GAP is unreachable; treat it as expiry so the FSM cannot stick.
    assign cnt_last = cnt_at_one || (cnt_count == '0);

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = len_eff;
        cnt_en       = 1'b0;
        drop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pulse_in) begin
                    state_d  = StHold;
                    cnt_load = 1'b1;
                end
            end
            StHold: begin
                if (pulse_in && retrigger_en) begin
                    cnt_load = 1'b1;
                end else begin
                    drop = pulse_in;
                    if (cnt_last) begin
                        if (gap_len == '0) begin
                            state_d = StIdle;
                            cnt_en  = 1'b1;
                        end else begin
                            state_d      = StGap;
                            cnt_load     = 1'b1;
                            cnt_load_val = gap_len;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            StGap: begin
                // The edge that closes the gap already behaves as IDLE and may start a level.
                if (cnt_last) begin
                    if (pulse_in) begin
                        state_d  = StHold;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_en  = 1'b1;
                    end
                end else begin
                    drop   = pulse_in;
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            level_q      <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= (state_d == StHold);
            busy_q       <= (state_d != StIdle);
            dropped_q    <= drop;
            drop_count_q <= drop_count_d;
        end
    end

    assign level_out  = level_q;
    assign busy       = busy_q;
    assign dropped    = dropped_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed table-driven bench for pulse_stretcher plus saturation and async-reset sequences.
module tb_pulse_stretcher;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DROP_W = 2;

    logic              clk;
    logic              reset_n;
    logic              pulse_in;
    logic [CNT_W-1:0]  pulse_len;
    logic [CNT_W-1:0]  gap_len;
    logic              retrigger_en;
    logic              level_out;
    logic              busy;
    logic              dropped;
    logic [DROP_W-1:0] drop_count;

    pulse_stretcher #(
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pulse_in     (pulse_in),
        .pulse_len    (pulse_len),
        .gap_len      (gap_len),
        .retrigger_en (retrigger_en),
        .level_out    (level_out),
        .busy         (busy),
        .dropped      (dropped),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              p;
        logic [CNT_W-1:0]  pl;
        logic [CNT_W-1:0]  gl;
        logic              rt;
        logic              lv;
        logic              bz;
        logic              dr;
        logic [DROP_W-1:0] dc;
        string             tag;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [CNT_W-1:0] cfg_pl;
    logic [CNT_W-1:0] cfg_gl;
    logic             cfg_rt;
    string            cfg_tag;

    task automatic cfg(input int pl, input int gl, input logic rt, input string tag);
        cfg_pl  = CNT_W'(pl);
        cfg_gl  = CNT_W'(gl);
        cfg_rt  = rt;
        cfg_tag = tag;
    endtask

    task automatic row(input logic p, input logic lv, input logic bz, input logic dr,
                       input int dc);
        vec_t v;
        v.p   = p;
        v.pl  = cfg_pl;
        v.gl  = cfg_gl;
        v.rt  = cfg_rt;
        v.lv  = lv;
        v.bz  = bz;
        v.dr  = dr;
        v.dc  = DROP_W'(dc);
        v.tag = cfg_tag;
        vecs.push_back(v);
    endtask

    // Outputs packed as {level_out, busy, dropped, drop_count}.
    task automatic check(input string name, input logic [DROP_W+2:0] exp);
        logic [DROP_W+2:0] got;
        got = {level_out, busy, dropped, drop_count};
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got lvl/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", name,
                     got[DROP_W+2], got[DROP_W+1], got[DROP_W], got[DROP_W-1:0],
                     exp[DROP_W+2], exp[DROP_W+1], exp[DROP_W], exp[DROP_W-1:0]);
        end
    endtask

    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        pulse_in     = 1'b0;
        pulse_len    = '0;
        gap_len      = '0;
        retrigger_en = 1'b0;

        // Basic stretch, L=5
        cfg(5, 0, 1'b0, "basic");
        row(1, 1, 1, 0, 0);
        repeat (4) row(0, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0);
        // Zero length acts as one cycle
        cfg(0, 0, 1'b0, "zero_len");
        row(1, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0);
        // Retrigger extends the level with no glitch
        cfg(4, 0, 1'b1, "retrig");
        row(1, 1, 1, 0, 0);
        row(0, 1, 1, 0, 0);
        row(0, 1, 1, 0, 0);
        row(1, 1, 1, 0, 0);
        repeat (3) row(0, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0);
        // Retrigger at the very last HOLD cycle
        cfg(2, 0, 1'b1, "retrig_last");
        row(1, 1, 1, 0, 0);
        row(1, 1, 1, 0, 0);
        row(0, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0);
        // Retrigger disabled: second pulse discarded
        cfg(4, 0, 1'b0, "no_retrig");
        row(1, 1, 1, 0, 0);
        row(0, 1, 1, 0, 0);
        row(1, 1, 1, 1, 1);
        row(0, 1, 1, 0, 1);
        row(0, 0, 0, 0, 1);
        // Gap enforcement, L=2 G=3
        cfg(2, 3, 1'b0, "gap");
        row(1, 1, 1, 0, 1);
        row(0, 1, 1, 0, 1);
        row(0, 0, 1, 0, 1);
        row(1, 0, 1, 1, 2);
        row(0, 0, 1, 0, 2);
        row(1, 1, 1, 0, 2);
        row(0, 1, 1, 0, 2);
        row(0, 0, 1, 0, 2);
        row(0, 0, 1, 0, 2);
        row(0, 0, 1, 0, 2);
        row(0, 0, 0, 0, 2);

        #12;
        check("reset_state", '0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0);
        check("idle_after_reset", '0);

        for (int i = 0; i < vecs.size(); i++) begin
            pulse_len    = vecs[i].pl;
            gap_len      = vecs[i].gl;
            retrigger_en = vecs[i].rt;
            step(vecs[i].p);
            check($sformatf("%s[%0d]", vecs[i].tag, i),
                  {vecs[i].lv, vecs[i].bz, vecs[i].dr, vecs[i].dc});
        end

        // Saturation: drop_count is 2 here; five discards stop it at 3
        pulse_len    = CNT_W'(20);
        gap_len      = '0;
        retrigger_en = 1'b0;
        step(1'b1);
        check("sat_accept", {1'b1, 1'b1, 1'b0, 2'd2});
        for (int i = 0; i < 5; i++) begin
            logic [DROP_W-1:0] exp_dc;
            exp_dc = (i == 0) ? 2'd3 : 2'd3;
            step(1'b1);
            check($sformatf("sat_drop%0d", i), {1'b1, 1'b1, 1'b1, exp_dc});
        end
        // Pulse len change outside a load instant must not disturb the running level
        pulse_len = CNT_W'(1);
        step(1'b0);
        check("sat_hold", {1'b1, 1'b1, 1'b0, 2'd3});

        // Asynchronous reset mid-HOLD, away from any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", '0);
        @(posedge clk);
        #1;
        check("reset_held", '0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0);
        check("post_reset_idle", '0);
        pulse_len = CNT_W'(1);
        step(1'b1);
        check("post_reset_accept", {1'b1, 1'b1, 1'b0, 2'd0});
        step(1'b0);
        check("post_reset_end", '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses (e.g. one-shot outputs from bit/frame event detectors) back into level signals of programmable duration, for LED drivers, timeout windows and slow-domain consumers in the CAN controller.
- Counterpart to the level-to-pulse one-shot: pulse in, level out.
- Enforces an optional dead-time (gap) after each level, with selectable retrigger, and counts discarded pulses.

Parameters:
- CNT_W, 8, width of the pulse_len/gap_len inputs and of the internal down-counter.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pulse_in  input  1  event pulse, sampled every rising clk edge
- pulse_len  input  CNT_W  level duration in cycles; 0 is treated as 1
- gap_len  input  CNT_W  dead-time in cycles after the level; 0 means no gap
- retrigger_en  input  1  1 = pulse_in during HOLD reloads the duration
- level_out  output  1  stretched level, registered
- busy  output  1  high in HOLD or GAP, registered
- dropped  output  1  one-cycle pulse when pulse_in is discarded
- drop_count  output  DROP_W  saturating count of discarded pulses

Behaviour:
- Interface: one clock, clk; reset_n asynchronous active-low.
- Reset (async assert, sync deassert by the system): state=IDLE, cnt=0, level_out=0, busy=0, dropped=0, drop_count=0.
- Reset asserted mid-HOLD or mid-GAP forces all of the above immediately; no completion of the level.
- pulse_len and gap_len are sampled only at load instants and may change freely at other times.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - pulse_in=1 at edge k loads cnt=max(pulse_len,1) and moves to HOLD.
  - level_out=1 and busy=1 after edge k; latency 1.
- HOLD:
  - level_out=1; cnt decrements each edge.
  - Level is high for exactly L=max(pulse_len,1) cycles with no retrigger: high after edges k..k+L-1, low after edge k+L.
  - At the edge where cnt==1 with no reload:
    - gap_len==0: go to IDLE, level_out=0, busy=0.
    - otherwise: go to GAP, cnt=gap_len, level_out=0, busy=1.
- Retrigger:
  - pulse_in=1 in HOLD with retrigger_en=1 reloads cnt=max(pulse_len,1) and stays in HOLD.
  - Includes the final HOLD cycle (cnt==1), so there is no low glitch.
  - Level ends L cycles after the last accepted pulse.
  - pulse_in=1 in HOLD with retrigger_en=0 is discarded.
- GAP:
  - level_out=0, busy=1; every pulse_in is discarded.
  - Lasts exactly G=gap_len cycles, then goes to IDLE.
  - A pulse on the final GAP edge is discarded.
  - A pulse on the next edge (IDLE) is accepted.
- Discard:
  - dropped=1 for the cycle following the discarded sample.
  - drop_count increments by 1 and saturates at 2^DROP_W-1.
  - drop_count clears only on reset.
- busy equals (state != IDLE), registered.
- level_out and busy are never X after reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package can_pulse_pkg:
  - state encoding constants: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2.
  - default widths CNT_W_DEF=8, DROP_W_DEF=8.
- One sub-module is natural: load_down_counter.
  - Ports: load, load_val, en, count, at_one.
  - Parameterised by CNT_W; shared by HOLD and GAP timing.
  - Reusable in the bit-timing logic.
- FSM, drop logic and output registers stay in pulse_stretcher.

Test Plan:
- Basic stretch: pulse_len=5, gap_len=0, single pulse_in at edge 10 -> level_out high after edges 10..14, low after edge 15; busy mirrors it; drop_count=0.
- Zero length: pulse_len=0, gap_len=0, pulse at edge 10 -> level_out high for exactly 1 cycle, low after edge 11.
- Retrigger: pulse_len=4, retrigger_en=1, pulses at edges 10 and 13 -> level_out continuously high after edges 10..16, low after edge 17; no dropped pulses.
- No retrigger: pulse_len=4, retrigger_en=0, pulses at edges 10 and 12 -> level high after edges 10..13; dropped=1 after edge 12; drop_count=1.
- Gap enforcement: pulse_len=2, gap_len=3, pulses at edges 10, 13 and 15:
  - level high after edges 10..11; GAP after edges 12..14.
  - pulse at 13 dropped (drop_count=1).
  - pulse at 15 accepted: level high after edges 15..16.
- Saturation and reset: DROP_W=2, retrigger_en=0, pulse_len=20, 5 extra pulses during HOLD -> drop_count stops at 3; reset_n low mid-HOLD -> level_out, busy and drop_count go to 0 immediately, asynchronously.
